// File: rtl/clmul_seq.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR), BITS_PER_CYCLE op2 bits per clock.
// Optional macro CLMUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module clmul_seq #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_start_i,
    input  logic [1:0]  s_function_i,
    input  logic [31:0] s_op1_i,
    input  logic [31:0] s_op2_i,
    input  logic        s_flush_i,
    output logic        s_busy_o,
    output logic        s_valid_o,
    output logic [31:0] s_result_o
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int ITER  = 32 / B;
    localparam int CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    generate
        if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16 || B == 32)) begin : g_bad_param
            $error("clmul_seq: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [63:0]       m_reg, m_next;
    logic [31:0]       q_reg, q_next;
    logic [63:0]       acc_reg, acc_next;
    logic [1:0]        fn_reg, fn_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       result_reg, result_next;
    logic              valid_reg, valid_next;

    logic [63:0]       pp [0:B];
    logic [63:0]       acc_step;
    logic [31:0]       q_shift;
    logic              finish;

    // XOR-accumulate the B partial products selected by the low multiplier bits.
    assign pp[0] = acc_reg;
    generate
        for (genvar gi = 0; gi < B; gi++) begin : g_pp
            assign pp[gi+1] = pp[gi] ^ (q_reg[gi] ? (m_reg << gi) : 64'd0);
        end
    endgenerate
    assign acc_step = pp[B];
    assign q_shift  = q_reg >> B;

`ifdef CLMUL_EARLY_EXIT_EN
    assign finish = (cnt_reg == LAST) || (q_shift == 32'd0);
`else
    assign finish = (cnt_reg == LAST);
`endif

    function automatic logic [31:0] select_result(input logic [1:0] f, input logic [63:0] a);
        logic [31:0] r;
        case (f)
            2'b00:   r = a[31:0];
            2'b01:   r = a[63:32];
            2'b10:   r = a[62:31];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_next  = state_reg;
        m_next      = m_reg;
        q_next      = q_reg;
        acc_next    = acc_reg;
        fn_next     = fn_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        valid_next  = 1'b0;

        if (s_flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                RUN: begin
                    m_next   = m_reg << B;
                    q_next   = q_shift;
                    acc_next = acc_step;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (finish) begin
                        state_next  = DONE;
                        result_next = select_result(fn_reg, acc_step);
                        valid_next  = 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (s_start_i) begin
                        state_next = RUN;
                        m_next     = {32'd0, s_op1_i};
                        q_next     = s_op2_i;
                        acc_next   = 64'd0;
                        fn_next    = s_function_i;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_reg  <= IDLE;
            m_reg      <= 64'd0;
            q_reg      <= 32'd0;
            acc_reg    <= 64'd0;
            fn_reg     <= 2'd0;
            cnt_reg    <= '0;
            result_reg <= 32'd0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            m_reg      <= m_next;
            q_reg      <= q_next;
            acc_reg    <= acc_next;
            fn_reg     <= fn_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
        end
    end

    assign s_busy_o   = (state_reg == RUN);
    assign s_valid_o  = valid_reg;
    assign s_result_o = result_reg;

endmodule
